slide_timer: RTL

//  Per-slide countdown timer for the presentation controller. Consumes the

---
 rtl/slide_timer.sv | 116 +++++++++++
 1 files changed

// File: rtl/slide_timer.sv
// Per-slide countdown timer: decrements on divided-tick rising edges, flags warn/expiry.
// Optional auto-advance behaviour is built when SLIDE_TIMER_AUTO_ADVANCE_EN is defined.
module slide_timer #(
  parameter int WIDTH       = 8,
  parameter int WARN_THRESH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             warn,
  output logic             expired,
  output logic             slide_adv
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] WARN_LIM = WIDTH'(WARN_THRESH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             tick_q;
  logic             tick_rise;

`ifdef SLIDE_TIMER_AUTO_ADVANCE_EN
  logic adv_q, adv_d;
`endif

  // The divider output is already a clk-domain register, so a plain edge detect suffices.
  assign tick_rise = tick_in & ~tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_in;
    end
  end

`ifdef SLIDE_TIMER_AUTO_ADVANCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adv_q <= 1'b0;
    else        adv_q <= adv_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef SLIDE_TIMER_AUTO_ADVANCE_EN
    adv_d       = 1'b0;
`endif
    if (clear) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else if (start) begin
      if (state_q == ST_PAUSED) begin
        state_d = ST_RUN;
      end else if (load_val == '0) begin
        state_d     = ST_EXPIRED;
        remaining_d = '0;
      end else begin
        state_d     = ST_RUN;
        remaining_d = load_val;
      end
    end else if (pause) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (tick_rise && state_q == ST_RUN) begin
      // <= 1 rather than == 1 so a count can never wrap below zero.
      if (remaining_q <= ONE) begin
`ifdef SLIDE_TIMER_AUTO_ADVANCE_EN
        if (load_val == '0) begin
          state_d     = ST_EXPIRED;
          remaining_d = '0;
        end else begin
          remaining_d = load_val;
          adv_d       = 1'b1;
        end
`else
        state_d     = ST_EXPIRED;
        remaining_d = '0;
`endif
      end else begin
        remaining_d = remaining_q - ONE;
      end
    end
  end

  assign remaining = remaining_q;
  assign running   = (state_q == ST_RUN);
  assign expired   = (state_q == ST_EXPIRED);
  assign warn      = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) &&
                     (remaining_q != '0) && (remaining_q <= WARN_LIM);

`ifdef SLIDE_TIMER_AUTO_ADVANCE_EN
  assign slide_adv = adv_q;
`else
  assign slide_adv = 1'b0;
`endif

endmodule
